pulse_indicator: RTL and testbench
==================================

PULSE_INDICATOR -- requirements
Module: pulse_indicator

Interface
REQ-001 The block SHALL have parameter ON_CYCLES, default 25_000_000, the number of clock cycles led is held high per event (>=1).
REQ-002 The block SHALL have parameter OFF_CYCLES, default 12_500_000, the minimum number of clock cycles led is held low between two events (>=1).
REQ-003 The block SHALL have parameter MAX_PENDING, default 7, the maximum number of queued events not yet displayed (>=1).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on posedge clk.
REQ-005 The block SHALL have port reset, input, 1 bit, a synchronous, active-high reset.
REQ-006 The block SHALL have port pulse, input, 1 bit, an active-high event strobe, normally one cycle wide, as produced by the key press-edge logic.
REQ-007 The block SHALL have port led, output, 1 bit, the active-high visible indicator.
REQ-008 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-009 The block SHALL have port pending, output, $clog2(MAX_PENDING+1) bits, the count of queued events.
REQ-010 The block SHALL have port overflow, output, 1 bit, a sticky flag set when an event is dropped.

Function
REQ-011 The state machine SHALL have exactly three states: IDLE, ON, and GAP.
REQ-012 Every cycle that pulse is sampled high SHALL count as one event; a pulse held high for N cycles SHALL count as N events.
REQ-013 From IDLE, when pulse is sampled high at edge E, the state SHALL become ON at E, the timer SHALL load ON_CYCLES-1, and led SHALL be 1 from E; pending SHALL NOT change.
REQ-014 In ON, the timer SHALL decrement each cycle; on the edge where the timer is 0, the state SHALL become GAP, the timer SHALL load OFF_CYCLES-1, and led SHALL become 0. As a result, led is high for exactly ON_CYCLES cycles.
REQ-015 In GAP, when the timer reaches 0 and pending>0, the state SHALL become ON with a fresh ON_CYCLES period and pending SHALL decrement; if pending==0, the state SHALL become IDLE.
REQ-016 A pulse sampled in ON or GAP SHALL increment pending if pending<MAX_PENDING; otherwise the event SHALL be dropped and overflow SHALL be set.
REQ-017 If a pulse arrives on the same edge that GAP dequeues an event, pending SHALL stay unchanged (+1 and -1 cancel), and that pulse SHALL never set overflow.
REQ-018 A pulse arriving on the same edge that GAP returns to IDLE (pending==0) SHALL increment pending to 1 and the state SHALL become IDLE; the following cycle SHALL dequeue it from IDLE, entering ON and decrementing pending.
REQ-019 From IDLE with pending>0, the state SHALL enter ON and decrement pending regardless of pulse; a simultaneous pulse SHALL increment pending, with a net change of 0.
REQ-020 overflow SHALL remain 1 until reset.
REQ-021 led, busy, pending, and overflow SHALL all be driven directly from registers, with no combinational path from pulse.
REQ-022 The timer width SHALL be $clog2(max(ON_CYCLES,OFF_CYCLES)).

Reset
REQ-023 When reset is high at a posedge, the next state SHALL be IDLE, timer=0, pending=0, led=0, busy=0, and overflow=0, overriding all other events.
REQ-024 A reset asserted mid-ON or mid-GAP SHALL discard the current blink and all queued events; a pulse in the reset cycle SHALL be ignored.

Structure
REQ-025 The package pulse_indicator_pkg SHALL hold the state enum (IDLE, ON, GAP) and the default constants for ON_CYCLES, OFF_CYCLES, and MAX_PENDING.
REQ-026 The loadable down-counter SHALL be one sub-module named cycle_timer, with inputs load and load_value and output zero; the FSM and pending counter SHALL stay in pulse_indicator.

Verification (ON_CYCLES=4, OFF_CYCLES=2, MAX_PENDING=3)
REQ-027 Scenario 1: a single pulse at edge 10 -> led=1 at edges 10-13, led=0 from edge 14; busy=1 at edges 10-15; IDLE at edge 16; pending=0 throughout.
REQ-028 Scenario 2: pulses at edges 10, 12, and 13 -> pending reaches 2; led high at edges 10-13, 16-19, and 22-25; IDLE at edge 28.
REQ-029 Scenario 3: pulse held high at edges 10-15 (6 events) -> the first is shown, pending saturates at 3, overflow=1 from edge 14, 4 blinks total, and overflow stays 1 afterward.
REQ-030 Scenario 4: a pulse exactly on the GAP-to-ON dequeue edge with pending=1 -> pending stays 1 and one extra blink follows; another pulse on the final GAP-to-IDLE edge -> pending=1 at that edge, then ON and pending=0 on the next edge.
REQ-031 Scenario 5: reset at edge 12 during ON with pending=2 -> at edge 12, led=0, busy=0, pending=0, and overflow=0; a pulse at edge 12 is ignored; a pulse at edge 13 starts a normal blink.
REQ-032 Scenario 6: 200 random pulses against a reference model -> the led high-period count equals accepted events, every high period is exactly 4 cycles, every low gap is >=2 cycles, and overflow matches the model.

Source files
------------

// File: rtl/pulse_indicator_pkg.sv
// Shared types and defaults for the pulse indicator: FSM state encoding,
// default timing/queue constants and the timer width helper.
package pulse_indicator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEFAULT_ON_CYCLES   = 25_000_000;
  localparam int DEFAULT_OFF_CYCLES  = 12_500_000;
  localparam int DEFAULT_MAX_PENDING = 7;

  // Wide enough to hold max(on, off) - 1; never narrower than one bit.
  function automatic int timer_width(input int on_cycles, input int off_cycles);
    int longest;
    longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter: load wins, otherwise counts down and parks at zero.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/pulse_indicator.sv
// Stretches short event strobes into visible LED blinks, queueing events that
// arrive while a blink or its trailing gap is still in progress.
module pulse_indicator
  import pulse_indicator_pkg::*;
#(
  parameter int ON_CYCLES   = DEFAULT_ON_CYCLES,
  parameter int OFF_CYCLES  = DEFAULT_OFF_CYCLES,
  parameter int MAX_PENDING = DEFAULT_MAX_PENDING
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pulse,
  output logic                               led,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam int PW = $clog2(MAX_PENDING + 1);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] MAX_P    = PW'(MAX_PENDING);
  localparam logic [PW-1:0] ONE      = PW'(1);

  state_t          state_reg;
  logic [PW-1:0]   pending_reg;
  logic            led_reg;
  logic            busy_reg;
  logic            overflow_reg;

  logic            timer_load;
  logic [TW-1:0]   timer_value;
  logic            timer_zero;
  logic            has_pending;

  assign has_pending = (pending_reg != '0);

  // The timer is loaded on exactly the edges where the FSM enters ON or GAP.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = ON_LOAD;
    case (state_reg)
      IDLE: timer_load = pulse || has_pending;
      ON: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = OFF_LOAD;
        end
      end
      GAP:     timer_load = timer_zero && has_pending;
      default: timer_load = 1'b0;
    endcase
  end

  cycle_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .zero      (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      led_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (has_pending || pulse) begin
            state_reg <= ON;
            led_reg   <= 1'b1;
            busy_reg  <= 1'b1;
            // A queued event is shown first; a simultaneous pulse replaces it in the queue.
            if (has_pending && !pulse) begin
              pending_reg <= pending_reg - ONE;
            end
          end
        end
        ON: begin
          if (pulse) begin
            if (pending_reg < MAX_P) pending_reg <= pending_reg + ONE;
            else overflow_reg <= 1'b1;
          end
          if (timer_zero) begin
            state_reg <= GAP;
            led_reg   <= 1'b0;
          end
        end
        GAP: begin
          if (timer_zero) begin
            if (has_pending) begin
              state_reg <= ON;
              led_reg   <= 1'b1;
              if (!pulse) pending_reg <= pending_reg - ONE;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              if (pulse) pending_reg <= pending_reg + ONE;
            end
          end else if (pulse) begin
            if (pending_reg < MAX_P) pending_reg <= pending_reg + ONE;
            else overflow_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          led_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign led      = led_reg;
  assign busy     = busy_reg;
  assign pending  = pending_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_pulse_indicator.sv
// Directed and randomized checks of pulse_indicator with ON=4, OFF=2, MAX_PENDING=3.
module tb_pulse_indicator;

  logic       clk;
  logic       reset;
  logic       pulse;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int e = 0;

  pulse_indicator #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (2),
    .MAX_PENDING(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pulse   (pulse),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed=%0d expected=%0d", tag, e, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int l, input int b, input int p);
    chk({tag, ".led"}, int'(led), l);
    chk({tag, ".busy"}, int'(busy), b);
    chk({tag, ".pending"}, int'(pending), p);
  endtask

  task automatic tick(input logic p, input logic r);
    pulse = p;
    reset = r;
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic start_scn(input string name);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk_out({name, ".reset"}, 0, 0, 0);
    chk({name, ".reset.overflow"}, int'(overflow), 0);
    e = 0;
    while (e < 9) tick(1'b0, 1'b0);
  endtask

  // Reference model for the random scenario
  int m_state, m_t, m_pend, m_ovf, m_drops;

  task automatic model_step(input logic p);
    case (m_state)
      0: begin
        if (m_pend > 0) begin m_state = 1; m_t = 3; m_pend = m_pend - 1 + int'(p); end
        else if (p) begin m_state = 1; m_t = 3; end
      end
      1: begin
        if (p) begin
          if (m_pend < 3) m_pend++;
          else begin m_ovf = 1; m_drops++; end
        end
        if (m_t == 0) begin m_state = 2; m_t = 1; end
        else m_t--;
      end
      default: begin
        if (m_t == 0) begin
          if (m_pend > 0) begin m_state = 1; m_t = 3; m_pend = m_pend - 1 + int'(p); end
          else begin m_state = 0; m_pend = m_pend + int'(p); end
        end else begin
          m_t--;
          if (p) begin
            if (m_pend < 3) m_pend++;
            else begin m_ovf = 1; m_drops++; end
          end
        end
      end
    endcase
  endtask

  initial begin
    int rises;
    logic led_prev;
    int npulses;
    int run_len;
    int cyc;
    logic p;

    reset = 1'b1;
    pulse = 1'b0;

    // Scenario 1: single pulse
    start_scn("s1");
    tick(1'b1, 1'b0);
    chk_out("s1", 1, 1, 0);
    for (int k = 11; k <= 17; k++) begin
      tick(1'b0, 1'b0);
      chk_out("s1", int'(k <= 13), int'(k <= 15), 0);
    end
    $display("scenario 1 single pulse done, edge %0d", e);

    // Scenario 2: pulses at 10, 12, 13
    start_scn("s2");
    for (int k = 10; k <= 29; k++) begin
      int ep;
      tick(k == 10 || k == 12 || k == 13, 1'b0);
      ep = (k == 12) ? 1 : (k >= 13 && k <= 15) ? 2 : (k >= 16 && k <= 21) ? 1 : 0;
      chk_out("s2", int'((k >= 10 && k <= 13) || (k >= 16 && k <= 19) || (k >= 22 && k <= 25)),
              int'(k <= 27), ep);
    end
    $display("scenario 2 queued pulses done, edge %0d", e);

    // Scenario 3: pulse held for 6 cycles saturates the queue
    start_scn("s3");
    rises = 0;
    led_prev = 1'b0;
    for (int k = 10; k <= 40; k++) begin
      tick(k <= 15, 1'b0);
      if (led && !led_prev) rises++;
      led_prev = led;
      if (k == 13) begin
        chk("s3.pending", int'(pending), 3);
        chk("s3.overflow_pre", int'(overflow), 0);
      end
      if (k == 14) chk("s3.overflow_set", int'(overflow), 1);
      if (k == 15) chk("s3.pending_sat", int'(pending), 3);
    end
    chk("s3.blinks", rises, 4);
    chk("s3.overflow_sticky", int'(overflow), 1);
    chk("s3.busy_end", int'(busy), 0);
    $display("scenario 3 held pulse done, edge %0d", e);

    // Scenario 4: pulses on the dequeue edge and on the GAP-to-IDLE edge
    start_scn("s4");
    rises = 0;
    led_prev = 1'b0;
    for (int k = 10; k <= 30; k++) begin
      tick(k == 10 || k == 12 || k == 16 || k == 28, 1'b0);
      if (led && !led_prev) rises++;
      led_prev = led;
      if (k == 12) chk("s4.pending12", int'(pending), 1);
      if (k == 16) chk_out("s4.e16", 1, 1, 1);
      if (k == 22) chk_out("s4.e22", 1, 1, 0);
      if (k == 28) chk_out("s4.e28", 0, 0, 1);
      if (k == 29) chk_out("s4.e29", 1, 1, 0);
    end
    chk("s4.blinks", rises, 4);
    chk("s4.overflow", int'(overflow), 0);
    $display("scenario 4 coincident pulses done, edge %0d", e);

    // Scenario 5: reset during ON with two queued events
    tick(1'b0, 1'b1);
    e = 0;
    while (e < 8) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk_out("s5.e11", 1, 1, 2);
    tick(1'b1, 1'b1);
    chk_out("s5.e12", 0, 0, 0);
    chk("s5.e12.overflow", int'(overflow), 0);
    tick(1'b1, 1'b0);
    chk_out("s5.e13", 1, 1, 0);
    for (int k = 14; k <= 17; k++) begin
      tick(1'b0, 1'b0);
      chk("s5.led", int'(led), int'(k <= 16));
    end
    $display("scenario 5 mid-blink reset done, edge %0d", e);

    // Scenario 6: random pulses against the reference model
    start_scn("s6");
    m_state = 0; m_t = 0; m_pend = 0; m_ovf = 0; m_drops = 0;
    npulses = 0;
    rises = 0;
    led_prev = 1'b0;
    run_len = 9;
    cyc = 0;
    while ((npulses < 200 || cyc < 60 + 2000) && cyc < 4000) begin
      p = (npulses < 200) && ($urandom_range(0, 3) == 0);
      if (npulses >= 200 && cyc < 2000) cyc = 2000;
      tick(p, 1'b0);
      model_step(p);
      if (p) npulses++;
      cyc++;
      if (led == led_prev) begin
        run_len++;
      end else begin
        if (led_prev) chk("s6.high_len", run_len, 4);
        else if (rises > 0) chk("s6.gap_ge2", int'(run_len >= 2), 1);
        if (led) rises++;
        run_len = 1;
      end
      led_prev = led;
    end
    chk("s6.pulses_sent", npulses, 200);
    chk("s6.blinks", rises, npulses - m_drops);
    chk("s6.overflow", int'(overflow), m_ovf);
    chk("s6.pending", int'(pending), m_pend);
    chk("s6.busy", int'(busy), 0);
    $display("scenario 6 random: %0d pulses, %0d dropped, %0d blinks", npulses, m_drops, rises);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
